cv32e40n_apu_responder: RTL

- Parametrised successor to the single-cycle APU dummy responder, sitting on the cv32e40p APU request/response port.
- Accepts up to DEPTH outstanding APU requests into an in-order request queue.
- Executes ALU ops with a configurable latency, and performs real load/store ops on the data memory interface while it holds mem_master_sel.
- Returns results strictly in acceptance order.

---
 rtl/cv32e40n_apu_resp_pkg.sv | 24 ++
 rtl/cv32e40p_apu_core_pkg.sv | 7 +
 rtl/cv32e40n_apu_req_fifo.sv | 51 +++++
 rtl/cv32e40n_apu_responder.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/cv32e40n_apu_resp_pkg.sv
// rtl/cv32e40n_apu_resp_pkg.sv - state, op-code, flag and queue entry definitions
package cv32e40n_apu_resp_pkg;
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EXEC,
        ST_MEM_REQ,
        ST_MEM_WAIT,
        ST_RESP
    } state_e;

    localparam logic [1:0] OP_ADD   = 2'd0;
    localparam logic [1:0] OP_LOAD  = 2'd1;
    localparam logic [1:0] OP_STORE = 2'd2;
    localparam logic [1:0] OP_ILL   = 2'd3;

    localparam int FLAG_ILL      = 0;
    localparam int FLAG_MISALIGN = 1;

    typedef struct packed {
        logic [1:0]  op;
        logic [31:0] op0;
        logic [31:0] op1;
    } req_entry_t;
endpackage

// File: rtl/cv32e40p_apu_core_pkg.sv
// rtl/cv32e40p_apu_core_pkg.sv - APU port widths shared with the cv32e40p core
package cv32e40p_apu_core_pkg;
    localparam int APU_NARGS_CPU    = 3;
    localparam int APU_WOP_CPU      = 6;
    localparam int APU_NDSFLAGS_CPU = 15;
    localparam int APU_NUSFLAGS_CPU = 5;
endpackage

// File: rtl/cv32e40n_apu_req_fifo.sv
// rtl/cv32e40n_apu_req_fifo.sv - in-order request queue, no push-on-full bypass
module cv32e40n_apu_req_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 66
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [AW:0]      count;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rdata   = mem[rptr];

    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem[wptr] <= wdata;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push_ok) begin
                wptr <= wptr + AW'(1);
            end
            if (pop_ok) begin
                rptr <= rptr + AW'(1);
            end
            count <= count + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop_ok};
        end
    end
endmodule

// File: rtl/cv32e40n_apu_responder.sv
// rtl/cv32e40n_apu_responder.sv - queued APU responder with ALU latency and OBI load/store
module cv32e40n_apu_responder
    import cv32e40p_apu_core_pkg::*;
    import cv32e40n_apu_resp_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int LATENCY   = 1,
    parameter int ADD_FLAGS = 1
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic [APU_NARGS_CPU-1:0][31:0]        apu_operands_i,
    input  logic [APU_WOP_CPU-1:0]                apu_op_i,
    input  logic [APU_NDSFLAGS_CPU-1:0]           apu_flags_i,
    input  logic                                  apu_req_i,
    output logic                                  apu_gnt_o,
    output logic                                  apu_rvalid_o,
    output logic [31:0]                           apu_result_o,
    output logic [APU_NUSFLAGS_CPU-1:0]           apu_flags_o,
    output logic                                  mem_master_sel,
    output logic                                  data_req_o,
    input  logic                                  data_gnt_i,
    input  logic                                  data_rvalid_i,
    output logic                                  data_we_o,
    output logic [3:0]                            data_be_o,
    output logic [31:0]                           data_addr_o,
    output logic [31:0]                           data_wdata_o,
    input  logic [31:0]                           data_rdata_i
);
    localparam logic [3:0] LAT_M1 = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

    function automatic logic [APU_NUSFLAGS_CPU-1:0] mk_flags(input logic ill, input logic mis);
        logic [APU_NUSFLAGS_CPU-1:0] f;
        f                = '0;
        f[FLAG_ILL]      = ill;
        f[FLAG_MISALIGN] = mis;
        return f;
    endfunction

    state_e                      state;
    req_entry_t                  push_entry;
    req_entry_t                  head;
    req_entry_t                  cur;
    logic                        fifo_full;
    logic                        fifo_empty;
    logic                        pop;
    logic [3:0]                  cnt;
    logic [APU_NUSFLAGS_CPU-1:0] flags_q;
    logic                        unused_inputs;

    // Debug-only / undecoded inputs are intentionally not consumed.
    assign unused_inputs = ^{apu_flags_i, apu_op_i[APU_WOP_CPU-1:2], apu_operands_i[APU_NARGS_CPU-1:2]};

    assign apu_gnt_o  = !fifo_full;
    assign push_entry = '{op: apu_op_i[1:0], op0: apu_operands_i[0], op1: apu_operands_i[1]};
    assign pop        = (state == ST_IDLE) && !fifo_empty;

    cv32e40n_apu_req_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(req_entry_t))
    ) u_req_fifo (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .push  (apu_req_i && apu_gnt_o),
        .wdata (push_entry),
        .pop   (pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign apu_flags_o = (ADD_FLAGS != 0) ? flags_q : '0;
    assign data_be_o   = data_req_o ? 4'hF : 4'h0;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state          <= ST_IDLE;
            cur            <= '0;
            cnt            <= '0;
            apu_result_o   <= '0;
            flags_q        <= '0;
            apu_rvalid_o   <= 1'b0;
            mem_master_sel <= 1'b0;
            data_req_o     <= 1'b0;
            data_we_o      <= 1'b0;
            data_addr_o    <= '0;
            data_wdata_o   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        cur <= head;
                        case (head.op)
                            OP_ADD: begin
                                if (LATENCY == 0) begin
                                    apu_result_o <= head.op0 + head.op1;
                                    flags_q      <= '0;
                                    apu_rvalid_o <= 1'b1;
                                    state        <= ST_RESP;
                                end else begin
                                    cnt   <= '0;
                                    state <= ST_EXEC;
                                end
                            end
                            OP_LOAD, OP_STORE: begin
                                // Misaligned addresses are still issued word-aligned.
                                mem_master_sel <= 1'b1;
                                data_req_o     <= 1'b1;
                                data_addr_o    <= {head.op0[31:2], 2'b00};
                                data_we_o      <= (head.op == OP_STORE);
                                data_wdata_o   <= head.op1;
                                state          <= ST_MEM_REQ;
                            end
                            default: begin
                                apu_result_o <= '0;
                                flags_q      <= mk_flags(1'b1, 1'b0);
                                apu_rvalid_o <= 1'b1;
                                state        <= ST_RESP;
                            end
                        endcase
                    end
                end
                ST_EXEC: begin
                    if (cnt == LAT_M1) begin
                        apu_result_o <= cur.op0 + cur.op1;
                        flags_q      <= '0;
                        apu_rvalid_o <= 1'b1;
                        state        <= ST_RESP;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                ST_MEM_REQ: begin
                    if (data_gnt_i) begin
                        data_req_o <= 1'b0;
                        state      <= ST_MEM_WAIT;
                    end
                end
                ST_MEM_WAIT: begin
                    if (data_rvalid_i) begin
                        mem_master_sel <= 1'b0;
                        apu_result_o   <= (cur.op == OP_LOAD) ? data_rdata_i : 32'd0;
                        flags_q        <= mk_flags(1'b0, cur.op0[1:0] != 2'b00);
                        apu_rvalid_o   <= 1'b1;
                        state          <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    apu_rvalid_o <= 1'b0;
                    state        <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end
endmodule
